// File: rtl/usiq_byte_streamer_if.sv
// -----------------------------------------------------------------------------
// usiq_byte_streamer_if
//
// Read-side bundle of the upstream-IQ sample FIFO, as seen by the byte
// streamer.
//
// Signals:
//   s_tdata   [23:0]      FIFO head word (one I or Q sample)
//   s_tvalid              FIFO head word is valid
//   s_tready              pop strobe, one-cycle pulse per word taken
//   s_tlast               end-of-packet marker; always marks a Q word
//   s_tlength [LEN_W-1:0] FIFO fill level
//
// Modports:
//   master : FIFO side; drives data, valid, last and length
//   slave  : streamer side; drives the pop strobe
// -----------------------------------------------------------------------------
interface usiq_byte_streamer_if #(
  parameter int LEN_W = 11
);

  logic [23:0]      s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic             s_tlast;
  logic [LEN_W-1:0] s_tlength;

  modport master (
    output s_tdata,
    output s_tvalid,
    output s_tlast,
    output s_tlength,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    input  s_tlast,
    input  s_tlength,
    output s_tready
  );

endinterface

// File: rtl/usiq_byte_streamer.sv
// -----------------------------------------------------------------------------
// usiq_byte_streamer
//
// Drains the usiq sample FIFO and serialises each I/Q pair into six bytes
// for the Raspberry Pi receive port. Each edge of the Pi byte clock, rising
// or falling, advances the output by one byte. Byte order is:
//   I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0]
//
// A small prefetch FSM keeps one complete pair ready, so the serialiser can
// switch to the next pair without a gap. If no pair is ready when one is
// due, the serialiser emits a fill pair and pulses underrun.
//
// Configuration macro:
//   USIQ_STREAMER_ZERO_FILL_EN  defined     : the fill pair is all zeros
//                               not defined : the fill pair repeats the last
//                                             transmitted pair
//
// Parameters:
//   THRESHOLD  FIFO level above which pi_rx_samples asserts
//   LEN_W      width of the FIFO level input
//
// Ports:
//   clk            sample clock (clk_ad9866)
//   rst            asynchronous, active-high reset
//   s_axis         FIFO read side (slave modport)
//   pi_rx_clk      asynchronous Pi byte clock
//   pi_rx_data     current byte, registered
//   pi_rx_samples  registered flag: FIFO level > THRESHOLD
//   underrun       one-cycle pulse; a pair was due but none was prefetched
//   misalign       one-cycle pulse; a tlast word was dropped from the I slot
// -----------------------------------------------------------------------------
module usiq_byte_streamer #(
  parameter int THRESHOLD = 256,
  parameter int LEN_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  usiq_byte_streamer_if.slave  s_axis,
  input  logic                 pi_rx_clk,
  output logic [7:0]           pi_rx_data,
  output logic                 pi_rx_samples,
  output logic                 underrun,
  output logic                 misalign
);

  typedef enum logic [1:0] {
    P_I    = 2'd0,
    P_Q    = 2'd1,
    P_FULL = 2'd2
  } pf_state_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } ser_state_e;

  // The threshold is widened to 32 bits so the level compare is unsigned
  // and does not depend on LEN_W.
  localparam logic [31:0] THR_U = THRESHOLD;

  // Selects byte i of a pair, most significant byte first.
  function automatic logic [7:0] byte_sel(input logic [47:0] w, input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = w[47:40];
      3'd1:    b = w[39:32];
      3'd2:    b = w[31:24];
      3'd3:    b = w[23:16];
      3'd4:    b = w[15:8];
      3'd5:    b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Byte clock synchroniser.
  logic sync1_q, sync2_q, sync3_q;
  logic edge_s;

  // Prefetch state.
  pf_state_e   pf_state_q;
  logic        popped_q;
  logic [23:0] pf_i_q;
  logic [23:0] pf_q_q;
  logic        misalign_q;

  // Serialiser state.
  ser_state_e  ser_state_q;
  logic [2:0]  idx_q;
  logic [47:0] sr_q;
  logic [7:0]  data_q;
  logic        underrun_q;

  // Level flag.
  logic        samples_q;

  // Combinational helpers.
  logic        pop_s;
  logic        pf_valid_s;
  logic [47:0] pair_data_s;
  logic [47:0] fill_s;
  logic        consume_s;
  logic [2:0]  next_idx_s;

  // Three-flop synchroniser; any change between the last two stages is one
  // byte-clock edge, rising or falling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= pi_rx_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_s = sync2_q ^ sync3_q;

  // Pop strobe. A pop is never issued in the cycle right after a pop, which
  // gives the FIFO a cycle to present its next head word. Reset blocks pops
  // so no word is taken while state is being cleared.
  assign pop_s = ~rst & ~popped_q & s_axis.s_tvalid &
                 ((pf_state_q == P_I) | (pf_state_q == P_Q));

  assign s_axis.s_tready = pop_s;

  // A pair is available when it is fully prefetched, or when the Q word is
  // being popped in this cycle. The second case lets a consume that lands
  // with the Q pop use the fresh pair directly.
  assign pf_valid_s = (pf_state_q == P_FULL) | ((pf_state_q == P_Q) & pop_s);

  // Source of the pair that is handed to the serialiser.
  always_comb begin
    pair_data_s = {pf_i_q, pf_q_q};
    if (pf_state_q == P_FULL) begin
      pair_data_s = {pf_i_q, pf_q_q};
    end else begin
      pair_data_s = {pf_i_q, s_axis.s_tdata};
    end
  end

`ifdef USIQ_STREAMER_ZERO_FILL_EN
  assign fill_s = 48'h0000_0000_0000;
`else
  assign fill_s = sr_q;
`endif

  // A pair is consumed on the edge that starts a new pair: the first edge
  // out of IDLE, or the edge after the last byte of the current pair.
  assign consume_s  = edge_s & pf_valid_s & ((ser_state_q == S_IDLE) | (idx_q == 3'd5));
  assign next_idx_s = idx_q + 3'd1;

  // Prefetch FSM: captures an I word and then a Q word, and holds the pair
  // until the serialiser consumes it. A tlast word in the I slot cannot
  // start a pair, so it is popped and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_state_q <= P_I;
      popped_q   <= 1'b0;
      pf_i_q     <= 24'h00_0000;
      pf_q_q     <= 24'h00_0000;
      misalign_q <= 1'b0;
    end else begin
      popped_q   <= pop_s;
      misalign_q <= 1'b0;
      case (pf_state_q)
        P_I: begin
          if (pop_s) begin
            if (s_axis.s_tlast) begin
              misalign_q <= 1'b1;
            end else begin
              pf_i_q     <= s_axis.s_tdata;
              pf_state_q <= P_Q;
            end
          end
        end
        P_Q: begin
          if (pop_s) begin
            pf_q_q <= s_axis.s_tdata;
            if (consume_s) begin
              pf_state_q <= P_I;
            end else begin
              pf_state_q <= P_FULL;
            end
          end
        end
        P_FULL: begin
          if (consume_s) begin
            pf_state_q <= P_I;
          end
        end
        default: begin
          pf_state_q <= P_I;
        end
      endcase
    end
  end

  // Serialiser FSM: presents one byte per byte-clock edge and chains pairs
  // back to back. If a new pair is due but none is ready, the fill pair is
  // sent instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_state_q <= S_IDLE;
      idx_q       <= 3'd0;
      sr_q        <= 48'h0000_0000_0000;
      data_q      <= 8'h00;
      underrun_q  <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      case (ser_state_q)
        S_IDLE: begin
          if (consume_s) begin
            sr_q        <= pair_data_s;
            data_q      <= pair_data_s[47:40];
            idx_q       <= 3'd0;
            ser_state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (edge_s) begin
            if (idx_q != 3'd5) begin
              data_q <= byte_sel(sr_q, next_idx_s);
              idx_q  <= next_idx_s;
            end else if (consume_s) begin
              sr_q   <= pair_data_s;
              data_q <= pair_data_s[47:40];
              idx_q  <= 3'd0;
            end else begin
              underrun_q <= 1'b1;
              sr_q       <= fill_s;
              data_q     <= fill_s[47:40];
              idx_q      <= 3'd0;
            end
          end
        end
        default: begin
          ser_state_q <= S_IDLE;
          idx_q       <= 3'd0;
        end
      endcase
    end
  end

  // Data-ready flag to the Pi, recomputed from the FIFO level every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples_q <= 1'b0;
    end else begin
      samples_q <= ({{(32-LEN_W){1'b0}}, s_axis.s_tlength} > THR_U);
    end
  end

  assign pi_rx_data    = data_q;
  assign pi_rx_samples = samples_q;
  assign underrun      = underrun_q;
  assign misalign      = misalign_q;

endmodule
